cm_bus_ctrl: RTL and testbench
==============================

Name: cm_bus_ctrl

Overview:
Sequences byte transfers over the shared 8-bit FPGA–MCU bus through the existing tri-state bus interface. Arbitrates bus direction between the FPGA transmitter and MCU-initiated writes using a 4-wire handshake:
- fpga_dir
- fpga_stb / mcu_ack
- mcu_stb / fpga_ack

Presents a valid/ready byte stream to FPGA-side logic. Sits between user logic and the tri-state interface (drives its data_out/drive_en, reads its data_in).

Parameters:
SYNC_STAGES, 2, flops in each async-input synchronizer (mcu_stb, mcu_ack); min 2
TURN_CYCLES, 2, cycles drive_en is held before fpga_stb rises (covers the interface's 1-cycle output register); min 1
TIMEOUT_CYCLES, 1024, handshake wait limit (used only with CM_BUS_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
tx_data  in  8  byte to send to MCU
tx_valid  in  1  tx_data valid
tx_ready  out  1  controller accepts tx_data this cycle
rx_data  out  8  byte received from MCU, held until next receive
rx_valid  out  1  1-cycle pulse, rx_data updated
err  out  1  1-cycle pulse on handshake timeout
busy  out  1  state != IDLE
bus_data_out  out  8  to interface data_out
bus_drive_en  out  1  to interface drive_en
bus_data_in  in  8  from interface data_in
fpga_dir  out  1  to MCU: FPGA claims bus
fpga_stb  out  1  to MCU: FPGA data valid
fpga_ack  out  1  to MCU: FPGA captured MCU data
mcu_stb  in  1  async from MCU: MCU data valid on bus
mcu_ack  in  1  async from MCU: MCU captured FPGA data

Behaviour:
- Reset: state IDLE; all outputs 0, including rx_data, bus_data_out and bus_drive_en. Synchronizers are cleared. Reset mid-transfer releases the bus on the next edge.
- mcu_stb and mcu_ack are synchronized (SYNC_STAGES flops) into stb_s and ack_s. All decisions use the synced versions.
- tx_ready = (state==IDLE) && !stb_s. On tx_valid && tx_ready, latch tx_data into bus_data_out, then go to CLAIM.
- IDLE: if stb_s, go to RX_ACK. RX has priority over a simultaneous tx_valid, and tx_ready is 0 that cycle.
- RX_ACK:
  - Capture rx_data <= bus_data_in and pulse rx_valid on entry.
  - Set fpga_ack=1 and wait for !stb_s.
  - Then drop fpga_ack and go to IDLE.
- CLAIM:
  - fpga_dir=1, bus_drive_en=0, for SYNC_STAGES+1 cycles.
  - If stb_s is seen during CLAIM (MCU raced), drop fpga_dir and go to RX_ACK. The latched tx byte stays pending and is retried via CLAIM after the RX returns to IDLE; tx_ready stays 0 meanwhile.
  - Otherwise go to DRIVE.
- DRIVE: fpga_dir=1, bus_drive_en=1, for TURN_CYCLES cycles, then go to TX_STB.
- TX_STB: fpga_stb=1; wait for ack_s=1, then go to TX_REL.
- TX_REL:
  - fpga_stb=0, bus stays driven; wait for ack_s=0.
  - Then drop bus_drive_en and fpga_dir together and go to IDLE.
  - Clear the pending flag.
- Bus contention rule: bus_drive_en=1 only in DRIVE, TX_STB and TX_REL. It is never 1 in the same cycle as fpga_ack.
- Latency: minimum tx transfer, accept to IDLE, is 1+(SYNC_STAGES+1)+TURN_CYCLES plus the MCU handshake round trips (each ≥ SYNC_STAGES).
- busy = (state != IDLE) || pending.

Optional Feature:
CM_BUS_TIMEOUT_EN
- Defined:
  - A counter runs in TX_STB, TX_REL and RX_ACK and clears on every state change.
  - On reaching TIMEOUT_CYCLES: deassert fpga_stb, fpga_ack, bus_drive_en and fpga_dir; drop the pending tx byte; pulse err; go to IDLE next cycle.
- Undefined: waits are unbounded, err is tied 0, and no counter logic is synthesized.

Decomposition:
- Package cm_bus_pkg: state enum (IDLE, CLAIM, DRIVE, TX_STB, TX_REL, RX_ACK) and default parameter constants.
- Sub-module cm_sync: parameterized SYNC_STAGES single-bit synchronizer with synchronous reset to 0, instantiated twice.

Test Plan:
1. Basic TX: tx_data=0xA5 with tx_valid pulse. Expect:
   - fpga_dir at +1.
   - bus_drive_en 3 cycles later.
   - fpga_stb after 2 more cycles, with bus_data_out=0xA5.
   - MCU model acks; bus_drive_en/fpga_dir fall only after ack_s low; tx_ready back to 1.
2. Basic RX: MCU drives 0x3C and raises mcu_stb. Expect rx_valid pulse with rx_data=0x3C and fpga_ack=1. MCU drops stb; fpga_ack falls; bus_drive_en stays 0 throughout.
3. Collision: tx_valid(0x11) accepted, then mcu_stb raised during CLAIM carrying 0x22. Expect:
   - rx_data=0x22 first, with bus_drive_en never 1 while mcu_stb high.
   - Then 0x11 transmitted automatically, with busy high until done.
4. Simultaneous: mcu_stb_s and tx_valid in the same IDLE cycle. Expect tx_ready=0, RX served, then tx accepted.
5. Reset mid-TX_STB: assert rst for 1 cycle. Next cycle all outputs are 0 and state IDLE; a subsequent tx completes normally.
6. (CM_BUS_TIMEOUT_EN, TIMEOUT_CYCLES=16) MCU never acks. Expect err pulse after 16 cycles in TX_STB, bus released, tx_ready=1.

Source files
------------

// File: rtl/cm_bus_pkg.sv
// Shared types and default constants for the FPGA-MCU byte bus controller.
package cm_bus_pkg;

    localparam int DATA_W             = 8;
    localparam int DEF_SYNC_STAGES    = 2;
    localparam int DEF_TURN_CYCLES    = 2;
    localparam int DEF_TIMEOUT_CYCLES = 1024;

    typedef enum logic [2:0] {
        IDLE,
        CLAIM,
        DRIVE,
        TX_STB,
        TX_REL,
        RX_ACK
    } state_t;

endpackage

// File: rtl/cm_bus_ctrl_if.sv
// Tri-state bus interface signals plus the 4-wire FPGA/MCU handshake.
interface cm_bus_ctrl_if;
    import cm_bus_pkg::*;

    logic [DATA_W-1:0] bus_data_out;
    logic              bus_drive_en;
    logic [DATA_W-1:0] bus_data_in;
    logic              fpga_dir;
    logic              fpga_stb;
    logic              fpga_ack;
    logic              mcu_stb;
    logic              mcu_ack;

    // Controller side
    modport master (
        output bus_data_out, bus_drive_en, fpga_dir, fpga_stb, fpga_ack,
        input  bus_data_in, mcu_stb, mcu_ack
    );

    // Tri-state pad / MCU side
    modport slave (
        input  bus_data_out, bus_drive_en, fpga_dir, fpga_stb, fpga_ack,
        output bus_data_in, mcu_stb, mcu_ack
    );

endinterface

// File: rtl/cm_sync.sv
// Single-bit multi-flop synchronizer with synchronous clear.
module cm_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sr_p;

    always_ff @(posedge clk) begin
        if (rst) sr_p <= '0;
        else     sr_p <= {sr_p[STAGES-2:0], d};
    end

    assign q = sr_p[STAGES-1];

endmodule

// File: rtl/cm_bus_ctrl.sv
// FPGA-MCU shared bus byte sequencer: direction arbitration, TX/RX handshakes.
// Optional handshake timeout enabled with `define CM_BUS_TIMEOUT_EN.
module cm_bus_ctrl
    import cm_bus_pkg::*;
#(
    parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int TURN_CYCLES    = DEF_TURN_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              err,
    output logic              busy,
    cm_bus_ctrl_if.master     bus
);

    localparam int CNT_MAX = (SYNC_STAGES > TURN_CYCLES) ? SYNC_STAGES : TURN_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    if (SYNC_STAGES < 2) begin : g_chk_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (TURN_CYCLES < 1) begin : g_chk_turn
        $error("TURN_CYCLES must be at least 1");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_chk_tout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              pending;
    logic [DATA_W-1:0] tx_byte;
    logic [DATA_W-1:0] rx_byte;
    logic              rx_pulse;
    logic              stb_s, ack_s;
    logic              accept, rx_enter, tx_done, to_hit;

    cm_sync #(.STAGES(SYNC_STAGES)) u_sync_stb (
        .clk (clk),
        .rst (rst),
        .d   (bus.mcu_stb),
        .q   (stb_s)
    );

    cm_sync #(.STAGES(SYNC_STAGES)) u_sync_ack (
        .clk (clk),
        .rst (rst),
        .d   (bus.mcu_ack),
        .q   (ack_s)
    );

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        rx_enter  = 1'b0;
        tx_done   = 1'b0;
        case (state)
            IDLE: begin
                // MCU data wins; a pending byte from a lost race is retried before new input
                if (stb_s) begin
                    state_nxt = RX_ACK;
                    rx_enter  = 1'b1;
                end else if (pending) begin
                    state_nxt = CLAIM;
                end else if (tx_valid) begin
                    state_nxt = CLAIM;
                    accept    = 1'b1;
                end
            end
            CLAIM: begin
                if (stb_s) begin
                    state_nxt = RX_ACK;
                    rx_enter  = 1'b1;
                end else if (cnt == CNT_W'(SYNC_STAGES)) begin
                    state_nxt = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt == CNT_W'(TURN_CYCLES - 1)) state_nxt = TX_STB;
            end
            TX_STB: begin
                if (ack_s) state_nxt = TX_REL;
            end
            TX_REL: begin
                if (!ack_s) begin
                    state_nxt = IDLE;
                    tx_done   = 1'b1;
                end
            end
            RX_ACK: begin
                if (!stb_s) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        if (to_hit) begin
            state_nxt = IDLE;
            tx_done   = 1'b1;
        end

        if ((state_nxt != state) || !(state inside {CLAIM, DRIVE})) cnt_nxt = '0;
        else                                                        cnt_nxt = cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            pending  <= 1'b0;
            tx_byte  <= '0;
            rx_byte  <= '0;
            rx_pulse <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            rx_pulse <= rx_enter;
            if (accept) begin
                pending <= 1'b1;
                tx_byte <= tx_data;
            end else if (tx_done) begin
                pending <= 1'b0;
            end
            if (rx_enter) rx_byte <= bus.bus_data_in;
        end
    end

`ifdef CM_BUS_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt;
    logic            waiting;
    logic            err_r;

    assign waiting = state inside {TX_STB, TX_REL, RX_ACK};
    assign to_hit  = waiting && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt <= '0;
            err_r  <= 1'b0;
        end else begin
            err_r <= to_hit;
            if ((state_nxt != state) || !waiting) to_cnt <= '0;
            else                                  to_cnt <= to_cnt + 1'b1;
        end
    end

    assign err = err_r;
`else
    assign to_hit = 1'b0;
    assign err    = 1'b0;
`endif

    // Bus pins are decoded from state so a reset or timeout releases them on the same edge
    assign bus.bus_data_out = tx_byte;
    assign bus.bus_drive_en = state inside {DRIVE, TX_STB, TX_REL};
    assign bus.fpga_dir     = state inside {CLAIM, DRIVE, TX_STB, TX_REL};
    assign bus.fpga_stb     = (state == TX_STB);
    assign bus.fpga_ack     = (state == RX_ACK);

    assign tx_ready = (state == IDLE) && !stb_s && !pending;
    assign busy     = (state != IDLE) || pending;
    assign rx_data  = rx_byte;
    assign rx_valid = rx_pulse;

endmodule

// File: tb/tb_cm_bus_ctrl.sv
// Directed, table-driven bench for cm_bus_ctrl (TX, RX, collision, reset, timeout).
module tb_cm_bus_ctrl;
    import cm_bus_pkg::*;

    localparam int SYNC = 2;
    localparam int TURN = 2;
    localparam int TOUT = 16;
    localparam int BOUND = 60;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       err;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int viol_ack = 0;
    int viol_stb = 0;

    cm_bus_ctrl_if bus();

    cm_bus_ctrl #(
        .SYNC_STAGES    (SYNC),
        .TURN_CYCLES    (TURN),
        .TIMEOUT_CYCLES (TOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .err      (err),
        .busy     (busy),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (bus.bus_drive_en === 1'b1 && bus.fpga_ack === 1'b1) viol_ack++;
            if (bus.bus_drive_en === 1'b1 && bus.mcu_stb === 1'b1)  viol_stb++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation ran past its time limit");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit         rx;
        logic [7:0] data;
        int         lat;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // From a sample where fpga_stb is (or is about to be) high: ack and check release
    task automatic tx_complete(input logic [7:0] data);
        int n;
        n = 0;
        while (bus.fpga_stb !== 1'b1 && n < BOUND) begin tick(); n++; end
        check("tx_stb_seen", {31'd0, bus.fpga_stb}, 32'd1);
        check("tx_bus_data", {24'd0, bus.bus_data_out}, {24'd0, data});
        check("tx_drive_at_stb", {31'd0, bus.bus_drive_en}, 32'd1);
        bus.mcu_ack = 1'b1;
        n = 0;
        do begin tick(); n++; end while (bus.fpga_stb !== 1'b0 && n < BOUND);
        check("tx_stb_fall_lat", n, 32'd3);
        check("tx_rel_still_driven", {31'd0, bus.bus_drive_en}, 32'd1);
        check("tx_rel_dir", {31'd0, bus.fpga_dir}, 32'd1);
        bus.mcu_ack = 1'b0;
        n = 0;
        do begin tick(); n++; end while (bus.bus_drive_en !== 1'b0 && n < BOUND);
        check("tx_release_lat", n, 32'd3);
        check("tx_release_dir", {31'd0, bus.fpga_dir}, 32'd0);
        check("tx_ready_after", {31'd0, tx_ready}, 32'd1);
        check("busy_after_tx", {31'd0, busy}, 32'd0);
    endtask

    task automatic do_tx(input logic [7:0] data, input int exp_lat);
        int n;
        int first_drv;
        check("tx_ready_before", {31'd0, tx_ready}, 32'd1);
        tx_data  = data;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        n = 1;
        first_drv = -1;
        check("tx_dir_plus1", {31'd0, bus.fpga_dir}, 32'd1);
        check("tx_busy", {31'd0, busy}, 32'd1);
        while (bus.fpga_stb !== 1'b1 && n < BOUND) begin
            tick();
            n++;
            if (first_drv < 0 && bus.bus_drive_en === 1'b1) first_drv = n;
        end
        check("tx_drive_lat", first_drv, 32'd4);
        check("tx_stb_lat", n, exp_lat);
        tx_complete(data);
    endtask

    task automatic do_rx(input logic [7:0] data, input int exp_lat);
        int n;
        bus.bus_data_in = data;
        bus.mcu_stb     = 1'b1;
        n = 0;
        do begin tick(); n++; end while (rx_valid !== 1'b1 && n < BOUND);
        check("rx_valid_lat", n, exp_lat);
        check("rx_data", {24'd0, rx_data}, {24'd0, data});
        check("rx_fpga_ack", {31'd0, bus.fpga_ack}, 32'd1);
        check("rx_no_drive", {31'd0, bus.bus_drive_en}, 32'd0);
        tick();
        check("rx_valid_pulse", {31'd0, rx_valid}, 32'd0);
        bus.mcu_stb     = 1'b0;
        bus.bus_data_in = 8'hEE;
        n = 0;
        do begin tick(); n++; end while (bus.fpga_ack !== 1'b0 && n < BOUND);
        check("rx_ack_fall_lat", n, 32'd3);
        check("rx_data_held", {24'd0, rx_data}, {24'd0, data});
        check("tx_ready_after_rx", {31'd0, tx_ready}, 32'd1);
    endtask

    initial begin
        int n;
        vecs[0] = '{rx: 1'b0, data: 8'hA5, lat: 6};
        vecs[1] = '{rx: 1'b1, data: 8'h3C, lat: 3};
        vecs[2] = '{rx: 1'b0, data: 8'h00, lat: 6};
        vecs[3] = '{rx: 1'b0, data: 8'hFF, lat: 6};
        vecs[4] = '{rx: 1'b1, data: 8'hC3, lat: 3};
        vecs[5] = '{rx: 1'b1, data: 8'h00, lat: 3};
        vecs[6] = '{rx: 1'b0, data: 8'h5A, lat: 6};

        rst             = 1'b1;
        tx_data         = 8'h00;
        tx_valid        = 1'b0;
        bus.bus_data_in = 8'h00;
        bus.mcu_stb     = 1'b0;
        bus.mcu_ack     = 1'b0;
        repeat (3) tick();
        check("rst_drive_en", {31'd0, bus.bus_drive_en}, 32'd0);
        check("rst_dir", {31'd0, bus.fpga_dir}, 32'd0);
        check("rst_stb", {31'd0, bus.fpga_stb}, 32'd0);
        check("rst_ack", {31'd0, bus.fpga_ack}, 32'd0);
        check("rst_bus_data", {24'd0, bus.bus_data_out}, 32'd0);
        check("rst_rx_data", {24'd0, rx_data}, 32'd0);
        check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        tick();
        check("idle_tx_ready", {31'd0, tx_ready}, 32'd1);

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].rx) do_rx(vecs[i].data, vecs[i].lat);
            else            do_tx(vecs[i].data, vecs[i].lat);
            tick();
        end

        // Collision: MCU raises stb while the controller is claiming the bus
        tx_data  = 8'h11;
        tx_valid = 1'b1;
        tick();
        tx_valid        = 1'b0;
        bus.bus_data_in = 8'h22;
        bus.mcu_stb     = 1'b1;
        n = 0;
        do begin tick(); n++; end while (rx_valid !== 1'b1 && n < BOUND);
        check("col_rx_lat", n, 32'd3);
        check("col_rx_data", {24'd0, rx_data}, 32'h22);
        check("col_dir_dropped", {31'd0, bus.fpga_dir}, 32'd0);
        check("col_tx_ready", {31'd0, tx_ready}, 32'd0);
        check("col_busy", {31'd0, busy}, 32'd1);
        tick();
        bus.mcu_stb = 1'b0;
        n = 0;
        do begin tick(); n++; end while (bus.fpga_ack !== 1'b0 && n < BOUND);
        check("col_ack_fall_lat", n, 32'd3);
        check("col_pending_busy", {31'd0, busy}, 32'd1);
        check("col_pending_ready", {31'd0, tx_ready}, 32'd0);
        tick();
        check("col_retry_dir", {31'd0, bus.fpga_dir}, 32'd1);
        tx_complete(8'h11);
        tick();

        // Simultaneous: synced stb and tx_valid in the same idle cycle
        bus.bus_data_in = 8'h3E;
        bus.mcu_stb     = 1'b1;
        tick();
        tick();
        tx_data  = 8'h77;
        tx_valid = 1'b1;
        check("sim_tx_ready_low", {31'd0, tx_ready}, 32'd0);
        tick();
        check("sim_rx_valid", {31'd0, rx_valid}, 32'd1);
        check("sim_rx_data", {24'd0, rx_data}, 32'h3E);
        check("sim_dir_low", {31'd0, bus.fpga_dir}, 32'd0);
        bus.mcu_stb = 1'b0;
        n = 0;
        do begin tick(); n++; end while (bus.fpga_ack !== 1'b0 && n < BOUND);
        check("sim_ack_fall_lat", n, 32'd3);
        check("sim_tx_ready_high", {31'd0, tx_ready}, 32'd1);
        tick();
        tx_valid = 1'b0;
        check("sim_tx_accepted", {31'd0, bus.fpga_dir}, 32'd1);
        tx_complete(8'h77);
        tick();

        // Reset while strobing a byte to the MCU
        tx_data  = 8'h99;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        n = 0;
        while (bus.fpga_stb !== 1'b1 && n < BOUND) begin tick(); n++; end
        check("rstmid_in_stb", {31'd0, bus.fpga_stb}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstmid_drive_en", {31'd0, bus.bus_drive_en}, 32'd0);
        check("rstmid_dir", {31'd0, bus.fpga_dir}, 32'd0);
        check("rstmid_stb", {31'd0, bus.fpga_stb}, 32'd0);
        check("rstmid_bus_data", {24'd0, bus.bus_data_out}, 32'd0);
        check("rstmid_rx_data", {24'd0, rx_data}, 32'd0);
        check("rstmid_busy", {31'd0, busy}, 32'd0);
        tick();
        do_tx(8'h42, 6);
        tick();

`ifdef CM_BUS_TIMEOUT_EN
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        n = 0;
        while (bus.fpga_stb !== 1'b1 && n < BOUND) begin tick(); n++; end
        n = 0;
        do begin tick(); n++; end while (err !== 1'b1 && n < BOUND);
        check("to_err_lat", n, TOUT);
        check("to_stb", {31'd0, bus.fpga_stb}, 32'd0);
        check("to_drive_en", {31'd0, bus.bus_drive_en}, 32'd0);
        check("to_dir", {31'd0, bus.fpga_dir}, 32'd0);
        check("to_tx_ready", {31'd0, tx_ready}, 32'd1);
        check("to_busy", {31'd0, busy}, 32'd0);
        tick();
        check("to_err_pulse", {31'd0, err}, 32'd0);
`else
        check("err_tied_low", {31'd0, err}, 32'd0);
`endif

        check("no_drive_with_fpga_ack", viol_ack, 32'd0);
        check("no_drive_with_mcu_stb", viol_stb, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
